// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main control FSM of the multi-cycle RV32I core. Every instruction walks
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over one shared memory port.
// This block drives the write enables and mux selects of the datapath, counts
// retired instructions and halts in TRAP on an illegal opcode or when memory
// fails to answer within MEM_TIMEOUT cycles.
//
// Parameters
//   MEM_TIMEOUT  max wait cycles on mem_ready in FETCH/MEM (0 = no timeout)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   opcode        IR[6:0], valid from DECODE onward
//   branch_taken  branch comparator result, valid in EXEC
//   mem_ready     memory completes the current request this cycle
//   mem_req       memory request
//   mem_we        store when 1
//   iord          address select: 0 = PC, 1 = ALU result
//   ir_we         load IR from memory read data
//   pc_we         update PC
//   pc_src        00 = PC+4, 01 = PC+imm, 10 = ALU result (JALR)
//   alu_src_a     0 = rs1, 1 = PC
//   alu_src_b     0 = rs2, 1 = imm
//   reg_we        register file write
//   wb_sel        00 = ALU, 01 = mem rdata, 10 = PC+4, 11 = imm
//   retire        one-cycle pulse per completed instruction
//   instret       retired-instruction count (wraps)
//   trap          sticky halt flag
//   trap_cause    01 = illegal opcode, 10 = memory timeout
//   state_dbg     current state encoding
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R      = 4'd0,
        C_I      = 4'd1,
        C_LOAD   = 4'd2,
        C_STORE  = 4'd3,
        C_BRANCH = 4'd4,
        C_LUI    = 4'd5,
        C_AUIPC  = 4'd6,
        C_JAL    = 4'd7,
        C_JALR   = 4'd8,
        C_ILL    = 4'd9
    } class_t;

    // Wait counter only needs to reach MEM_TIMEOUT-1; with the timeout
    // disabled it is a harmless 1-bit toggle.
    localparam int              TO_W    = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam bit              TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t            r_state;
    state_t            w_state_next;
    class_t            r_class;
    class_t            w_class_dec;
    logic [TO_W-1:0]   r_to_cnt;
    logic [CNT_W-1:0]  r_instret;
    logic [1:0]        r_trap_cause;
    logic [1:0]        w_trap_cause_next;
    logic              w_to_hit;
    logic              w_sel_a;
    logic              w_sel_b;

    logic              w_mem_req;
    logic              w_mem_we;
    logic              w_iord;
    logic              w_ir_we;
    logic              w_pc_we;
    logic [1:0]        w_pc_src;
    logic              w_alu_src_a;
    logic              w_alu_src_b;
    logic              w_reg_we;
    logic [1:0]        w_wb_sel;
    logic              w_retire;

    // Opcode classification, consumed only while in DECODE.
    always_comb begin
        w_class_dec = C_ILL;
        case (opcode)
            7'b0110011: w_class_dec = C_R;
            7'b0010011: w_class_dec = C_I;
            7'b0000011: w_class_dec = C_LOAD;
            7'b0100011: w_class_dec = C_STORE;
            7'b1100011: w_class_dec = C_BRANCH;
            7'b0110111: w_class_dec = C_LUI;
            7'b0010111: w_class_dec = C_AUIPC;
            7'b1101111: w_class_dec = C_JAL;
            7'b1100111: w_class_dec = C_JALR;
            default:    w_class_dec = C_ILL;
        endcase
    end

    // ALU operand selects per class; shared by EXEC and WB so the JALR
    // target computed in EXEC is still on the ALU output during WB.
    always_comb begin
        w_sel_a = 1'b0;
        w_sel_b = 1'b0;
        case (r_class)
            C_I, C_LOAD, C_STORE, C_JALR: w_sel_b = 1'b1;
            C_AUIPC: begin
                w_sel_a = 1'b1;
                w_sel_b = 1'b1;
            end
            default: ;
        endcase
    end

    // Expires on the wait cycle that would bring the count to MEM_TIMEOUT;
    // a mem_ready on that same cycle takes priority.
    assign w_to_hit = TO_EN && !mem_ready && (r_to_cnt == TO_LAST);

    // Next-state and output decode.
    always_comb begin
        w_state_next      = r_state;
        w_trap_cause_next = r_trap_cause;
        w_mem_req         = 1'b0;
        w_mem_we          = 1'b0;
        w_iord            = 1'b0;
        w_ir_we           = 1'b0;
        w_pc_we           = 1'b0;
        w_pc_src          = 2'b00;
        w_alu_src_a       = 1'b0;
        w_alu_src_b       = 1'b0;
        w_reg_we          = 1'b0;
        w_wb_sel          = 2'b00;
        w_retire          = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_we      = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_to_hit) begin
                    w_state_next      = S_TRAP;
                    w_trap_cause_next = 2'b10;
                end
            end
            S_DECODE: begin
                if (w_class_dec == C_ILL) begin
                    w_state_next      = S_TRAP;
                    w_trap_cause_next = 2'b01;
                end else begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_alu_src_a = w_sel_a;
                w_alu_src_b = w_sel_b;
                case (r_class)
                    C_BRANCH: begin
                        w_pc_we      = 1'b1;
                        w_pc_src     = branch_taken ? 2'b01 : 2'b00;
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    C_LOAD, C_STORE: w_state_next = S_MEM;
                    default:         w_state_next = S_WB;
                endcase
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mem_we  = (r_class == C_STORE);
                if (mem_ready) begin
                    if (r_class == C_STORE) begin
                        w_pc_we      = 1'b1;
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_to_hit) begin
                    w_state_next      = S_TRAP;
                    w_trap_cause_next = 2'b10;
                end
            end
            S_WB: begin
                w_alu_src_a  = w_sel_a;
                w_alu_src_b  = w_sel_b;
                w_reg_we     = 1'b1;
                w_pc_we      = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
                case (r_class)
                    C_LOAD: w_wb_sel = 2'b01;
                    C_LUI:  w_wb_sel = 2'b11;
                    C_JAL: begin
                        w_wb_sel = 2'b10;
                        w_pc_src = 2'b01;
                    end
                    C_JALR: begin
                        w_wb_sel = 2'b10;
                        w_pc_src = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_TRAP: w_state_next = S_TRAP;
            default: w_state_next = S_FETCH;
        endcase
    end

    // State, class, trap cause and instret registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_class      <= C_R;
            r_trap_cause <= 2'b00;
            r_instret    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_trap_cause <= w_trap_cause_next;
            if (r_state == S_DECODE) begin
                r_class <= w_class_dec;
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    // Wait counter: counts stalled cycles in FETCH/MEM and is zero on every
    // entry to those states because any other cycle clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Every output is forced low while rst is asserted, even before the
    // first clock edge has initialised the registers.
    assign mem_req    = !rst && w_mem_req;
    assign mem_we     = !rst && w_mem_we;
    assign iord       = !rst && w_iord;
    assign ir_we      = !rst && w_ir_we;
    assign pc_we      = !rst && w_pc_we;
    assign pc_src     = rst ? 2'b00 : w_pc_src;
    assign alu_src_a  = !rst && w_alu_src_a;
    assign alu_src_b  = !rst && w_alu_src_b;
    assign reg_we     = !rst && w_reg_we;
    assign wb_sel     = rst ? 2'b00 : w_wb_sel;
    assign retire     = !rst && w_retire;
    assign instret    = rst ? '0 : r_instret;
    assign trap       = !rst && (r_state == S_TRAP);
    assign trap_cause = rst ? 2'b00 : r_trap_cause;
    assign state_dbg  = rst ? 3'd0 : r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic          branch_taken;
    logic          mem_ready;
    logic          mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0]    pc_src;
    logic          alu_src_a, alu_src_b, reg_we;
    logic [1:0]    wb_sel;
    logic          retire;
    logic [CW-1:0] instret;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [2:0]    state_dbg;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire),
        .instret(instret), .trap(trap), .trap_cause(trap_cause), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_instret = '0;
    logic [6:0]    legal [9];

    logic [18:0] obs;
    assign obs = {state_dbg, mem_req, mem_we, iord, ir_we, pc_we, pc_src,
                  alu_src_a, alu_src_b, reg_we, wb_sel, retire, trap, trap_cause};

    // Expected output vector for one cycle of an instruction, by phase
    // (0 fetch, 1 decode, 2 exec, 3 mem, 4 writeback, 5 trap).
    function automatic logic [18:0] expv(input int ph, input logic [6:0] opc,
                                         input logic rdy, input logic bt,
                                         input logic [1:0] cause);
        logic req; logic we; logic ird; logic irw; logic pcw; logic [1:0] src;
        logic a; logic b; logic rw; logic [1:0] wb; logic ret; logic tr; logic [1:0] tc;
        req = 0; we = 0; ird = 0; irw = 0; pcw = 0; src = 2'b00;
        a = 0; b = 0; rw = 0; wb = 2'b00; ret = 0; tr = 0; tc = 2'b00;
        case (ph)
            0: begin req = 1; irw = rdy; end
            2: begin
                a = (opc == OP_AUIPC);
                b = (opc == OP_I || opc == OP_LOAD || opc == OP_STORE ||
                     opc == OP_JALR || opc == OP_AUIPC);
                if (opc == OP_BRANCH) begin pcw = 1; src = bt ? 2'b01 : 2'b00; ret = 1; end
            end
            3: begin
                req = 1; ird = 1; we = (opc == OP_STORE);
                if (rdy && opc == OP_STORE) begin pcw = 1; ret = 1; end
            end
            4: begin
                a = (opc == OP_AUIPC);
                b = (opc == OP_I || opc == OP_LOAD || opc == OP_JALR || opc == OP_AUIPC);
                rw = 1; pcw = 1; ret = 1;
                if (opc == OP_LOAD) wb = 2'b01;
                if (opc == OP_LUI)  wb = 2'b11;
                if (opc == OP_JAL)  begin wb = 2'b10; src = 2'b01; end
                if (opc == OP_JALR) begin wb = 2'b10; src = 2'b10; end
            end
            5: begin tr = 1; tc = cause; end
            default: ;
        endcase
        return {3'(ph), req, we, ird, irw, pcw, src, a, b, rw, wb, ret, tr, tc};
    endfunction

    // One clock cycle: inputs applied just after posedge, outputs checked at negedge.
    task automatic step(input logic rdy, input logic [6:0] opc, input logic bt,
                        input logic [18:0] exp, input string tag);
        mem_ready    = rdy;
        opcode       = opc;
        branch_taken = bt;
        @(negedge clk);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        total++;
        assert (instret === exp_instret) else begin
            bad++;
            $error("FAIL %s: observed instret=%0d expected=%0d", tag, instret, exp_instret);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] junk();
        return 7'($urandom);
    endfunction

    // Full instruction with fw fetch wait cycles and mw memory wait cycles.
    task automatic run_instr(input logic [6:0] opc, input logic bt, input int fw, input int mw);
        bit is_mem;
        bit has_wb;
        is_mem = (opc == OP_LOAD || opc == OP_STORE);
        has_wb = !(opc == OP_BRANCH || opc == OP_STORE);
        for (int i = 0; i < fw; i++) step(1'b0, junk(), rb(), expv(0, opc, 1'b0, 1'b0, 2'b00), "fetch_wait");
        step(1'b1, junk(), rb(), expv(0, opc, 1'b1, 1'b0, 2'b00), "fetch");
        step(rb(), opc, rb(), expv(1, opc, 1'b0, 1'b0, 2'b00), "decode");
        step(rb(), opc, bt, expv(2, opc, 1'b0, bt, 2'b00), "exec");
        if (is_mem) begin
            for (int i = 0; i < mw; i++) step(1'b0, opc, rb(), expv(3, opc, 1'b0, 1'b0, 2'b00), "mem_wait");
            step(1'b1, opc, rb(), expv(3, opc, 1'b1, 1'b0, 2'b00), "mem");
        end
        if (has_wb) step(rb(), opc, rb(), expv(4, opc, 1'b0, 1'b0, 2'b00), "wb");
        exp_instret++;
        chk_cnt("instret");
        $display("instr op=%b taken=%0d fw=%0d mw=%0d instret=%0d", opc, bt, fw, mw, instret);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step(1'b0, junk(), rb(), 19'd0, tag);
        rst = 1'b0;
        exp_instret = '0;
        chk_cnt({tag, "_cnt"});
    endtask

    initial begin
        legal[0] = OP_R;   legal[1] = OP_I;     legal[2] = OP_LOAD;
        legal[3] = OP_STORE; legal[4] = OP_BRANCH; legal[5] = OP_LUI;
        legal[6] = OP_AUIPC; legal[7] = OP_JAL;  legal[8] = OP_JALR;

        rst = 1'b1; mem_ready = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        // Directed instructions
        run_instr(OP_I, 1'b0, 0, 0);        // ADDI 0x00500093
        run_instr(OP_LOAD, 1'b0, 0, 2);     // LW, 2 memory wait cycles
        run_instr(OP_BRANCH, 1'b1, 0, 0);   // BEQ taken
        run_instr(OP_BRANCH, 1'b0, 0, 0);   // BEQ not taken
        run_instr(OP_JALR, 1'b0, 0, 0);     // JALR 0x000080E7
        run_instr(OP_STORE, 1'b0, 0, 0);    // SW
        run_instr(OP_LUI, 1'b0, 1, 0);
        run_instr(OP_JAL, 1'b0, 0, 0);
        run_instr(OP_AUIPC, 1'b0, 2, 0);

        // Random instruction stream (waits kept below the timeout)
        for (int n = 0; n < 40; n++) begin
            run_instr(legal[$urandom_range(0, 8)], rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while a load is waiting in MEM abandons the request
        step(1'b1, junk(), rb(), expv(0, OP_LOAD, 1'b1, 1'b0, 2'b00), "rm_fetch");
        step(rb(), OP_LOAD, rb(), expv(1, OP_LOAD, 1'b0, 1'b0, 2'b00), "rm_decode");
        step(rb(), OP_LOAD, rb(), expv(2, OP_LOAD, 1'b0, 1'b0, 2'b00), "rm_exec");
        step(1'b0, OP_LOAD, rb(), expv(3, OP_LOAD, 1'b0, 1'b0, 2'b00), "rm_mem");
        do_reset("rm_rst");
        run_instr(OP_R, 1'b0, 0, 0);
        run_instr(OP_I, 1'b0, 0, 1);

        // Illegal opcode 0x7F
        step(1'b1, junk(), rb(), expv(0, 7'h7F, 1'b1, 1'b0, 2'b00), "ill_fetch");
        step(rb(), 7'h7F, rb(), expv(1, 7'h7F, 1'b0, 1'b0, 2'b00), "ill_decode");
        for (int i = 0; i < 20; i++) step(rb(), junk(), rb(), expv(5, 7'h7F, 1'b0, 1'b0, 2'b01), "ill_trap");
        chk_cnt("ill_frozen");
        $display("illegal opcode trap held, instret=%0d", instret);
        do_reset("ill_rst");

        // Fetch timeout: no ready for 4 cycles
        for (int i = 0; i < 4; i++) step(1'b0, junk(), rb(), expv(0, OP_R, 1'b0, 1'b0, 2'b00), "to_fetch");
        for (int i = 0; i < 3; i++) step(rb(), junk(), rb(), expv(5, OP_R, 1'b0, 1'b0, 2'b10), "to_trap");
        chk_cnt("to_frozen");
        $display("fetch timeout trap");
        do_reset("to_rst");

        // Ready arriving on the 4th wait cycle completes normally
        run_instr(OP_R, 1'b0, 3, 0);
        run_instr(OP_STORE, 1'b0, 0, 3);

        // Memory-stage timeout
        step(1'b1, junk(), rb(), expv(0, OP_LOAD, 1'b1, 1'b0, 2'b00), "mto_fetch");
        step(rb(), OP_LOAD, rb(), expv(1, OP_LOAD, 1'b0, 1'b0, 2'b00), "mto_decode");
        step(rb(), OP_LOAD, rb(), expv(2, OP_LOAD, 1'b0, 1'b0, 2'b00), "mto_exec");
        for (int i = 0; i < 4; i++) step(1'b0, OP_LOAD, rb(), expv(3, OP_LOAD, 1'b0, 1'b0, 2'b00), "mto_mem");
        for (int i = 0; i < 2; i++) step(rb(), OP_LOAD, rb(), expv(5, OP_LOAD, 1'b0, 1'b0, 2'b10), "mto_trap");
        chk_cnt("mto_frozen");
        $display("memory timeout trap");
        do_reset("mto_rst");
        run_instr(OP_I, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback over a single shared memory port.
- Drives write enables and mux selects for PC, IR, ALU operands, register file and writeback path.
- The immediate generator decodes IR directly; this block only selects when its output is consumed. It also counts retired instructions and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 0: max wait cycles for mem_ready in FETCH/MEM before trap; 0 disables timeout.
- CNT_W, 32: width of instret counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- branch_taken  in  1  branch comparator result; valid in EXEC.
- mem_ready  in  1  memory completes request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  store when 1.
- iord  out  1  address select: 0 = PC, 1 = ALU result.
- ir_we  out  1  load IR from mem rdata.
- pc_we  out  1  update PC.
- pc_src  out  2  00 = PC+4, 01 = PC+imm, 10 = ALU result (JALR).
- alu_src_a  out  1  0 = rs1, 1 = PC.
- alu_src_b  out  1  0 = rs2, 1 = imm.
- reg_we  out  1  register file write.
- wb_sel  out  2  00 = ALU, 01 = mem rdata, 10 = PC+4, 11 = imm.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count.
- trap  out  1  sticky halt flag.
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset: while rst = 1, all outputs are driven 0.
  - state <= FETCH, instret <= 0, trap/trap_cause <= 0, timeout counter <= 0.
  - rst overrides everything, including TRAP and mid-transfer states; an outstanding memory request is abandoned.
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5.
- FETCH: mem_req = 1, iord = 0.
  - On mem_ready: ir_we = 1, go to DECODE.
  - Otherwise stay.
- DECODE: latch opcode into a class register.
  - Legal classes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - Any other opcode: go to TRAP, trap_cause = 01.
  - Otherwise go to EXEC.
- EXEC operand selects:
  - R: b = rs2.
  - I-ALU / LOAD / STORE / JALR: b = imm.
  - AUIPC: a = PC, b = imm.
  - BRANCH: a = rs1, b = rs2.
- EXEC transitions:
  - BRANCH: pc_we = 1, pc_src = branch_taken ? 01 : 00, retire = 1, go to FETCH.
  - LOAD / STORE: go to MEM.
  - All other classes: go to WB.
- MEM: mem_req = 1, iord = 1, mem_we = (class == STORE).
  - On mem_ready, STORE: pc_we = 1, pc_src = 00, retire = 1, go to FETCH.
  - On mem_ready, LOAD: go to WB.
- WB: reg_we = 1, pc_we = 1, retire = 1, go to FETCH. Per class:
  - R / I-ALU / AUIPC: wb_sel = 00, pc_src = 00.
  - LOAD: wb_sel = 01, pc_src = 00.
  - LUI: wb_sel = 11, pc_src = 00.
  - JAL: wb_sel = 10, pc_src = 01.
  - JALR: wb_sel = 10, pc_src = 10; the datapath clears bit 0.
  - ALU operand selects hold their EXEC values during WB, so JALR target stays valid.
- TRAP: trap = 1 and all enables 0. Held until rst.
- Outputs are combinational from state, class, mem_ready and branch_taken. Undriven selects are 0.
- Latency with zero-wait memory (mem_ready high in the first request cycle):
  - BRANCH 3 cycles.
  - R / I / LUI / AUIPC / JAL / JALR / STORE 4 cycles.
  - LOAD 5 cycles.
  - Each wait cycle adds 1.
- Timeout counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle in FETCH/MEM while mem_ready = 0.
  - If MEM_TIMEOUT != 0 and the count reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP with trap_cause = 10.
  - mem_ready arriving on the same cycle the count would reach the limit wins (completes normally).
- instret: increments on retire and wraps modulo 2^CNT_W. It is frozen in TRAP.
- x0 writes: reg_we is asserted regardless of rd; the register file ignores rd = 0.

Test Plan:
- Reset, zero-wait memory, ADDI 0x00500093 → states F, D, E, W; alu_src_b = 1, wb_sel = 00, reg_we high in cycle 4; retire pulse; instret = 1.
- LW with mem_ready delayed 2 cycles in MEM → MEM held 3 cycles, mem_we = 0, iord = 1; WB wb_sel = 01; total 7 cycles.
- BEQ, branch_taken = 1 then 0 → pc_src 01 vs 00, pc_we = 1 in EXEC, no reg_we, 3 cycles each; instret + 2.
- JALR 0x000080E7 → WB: wb_sel = 10, pc_src = 10, reg_we = 1; SW next → MEM with mem_we = 1, no reg_we.
- Opcode 0x7F → TRAP after DECODE, trap_cause = 01, all enables 0 for 20 cycles; rst pulse returns to FETCH with instret = 0.
- MEM_TIMEOUT = 4, mem_ready held low in FETCH → TRAP on 4th wait cycle, cause = 10. Repeat with mem_ready on the 4th cycle → normal DECODE.
